// File: rtl/nios_sdram_com_cmd.sv
// Avalon-MM command port: Nios writes 16-bit words into a small FIFO that
// drains through a registered valid/ready stage toward fabric logic.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   address/write/read  Avalon-MM slave strobes, 2-bit register select
//   writedata/readdata  32-bit bus data, readdata registered (1-cycle)
//   out_data/out_valid  command beat toward the consumer
//   out_ready           consumer accepts the presented beat
//   out_port            static copy of the last accepted word
//
// Register map:
//   0 DATA     write pushes word, read returns last word written
//   1 STATUS   {ovf[8], out_valid[5], count[4:2], full[1], empty[0]}
//              writing 1 to bit 8 clears the sticky overflow flag
//   2 CONTROL  bit0 enable (r/w), bit1 flush (write-1 pulse)
//   3 unused   reads 0
module nios_sdram_com_cmd #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic                  read,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  enable;
  logic [DATA_WIDTH-1:0] data_rb;

  logic                  wr_data;
  logic                  wr_stat;
  logic                  wr_ctrl;
  logic                  flush;
  logic                  empty;
  logic                  full;
  logic                  hs;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic [31:0]           status;
  logic [31:0]           rd_mux;

  // Read strobe is not needed: readdata tracks address every cycle.
  logic unused;
  assign unused = ^{read, writedata};

  assign wr_data = write && (address == A_DATA);
  assign wr_stat = write && (address == A_STAT);
  assign wr_ctrl = write && (address == A_CTRL);
  assign flush   = wr_ctrl && writedata[1];

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign hs    = out_valid && out_ready;

  // Refill the output stage whenever it is free or being drained now.
  assign pop = enable && !empty && !flush
            && (!out_valid || hs);

  // A full FIFO still accepts a word when the head leaves this cycle.
  assign push_ok = wr_data && !flush && (!full || pop);
  assign drop    = wr_data && !flush && full && !pop;

  always_comb begin
    status    = '0;
    status[0] = empty;
    status[1] = full;
    status[4:2] = 3'(count);
    status[5] = out_valid;
    status[8] = overflow;
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      A_DATA:  rd_mux = 32'(data_rb);
      A_STAT:  rd_mux = status;
      A_CTRL:  rd_mux = {31'd0, enable};
      default: rd_mux = '0;
    endcase
  end

  // Storage array carries no reset; pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      enable    <= 1'b0;
      data_rb   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_port  <= '0;
      readdata  <= '0;
    end else begin
      readdata <= rd_mux;

      if (wr_data) begin
        data_rb <= writedata[DATA_WIDTH-1:0];
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        unique case ({push_ok, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_stat && writedata[8]) begin
        overflow <= 1'b0;
      end

      if (wr_ctrl) begin
        enable <= writedata[0];
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (pop) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr];
      end else if (hs) begin
        out_valid <= 1'b0;
      end

      if (hs) begin
        out_port <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_nios_sdram_com_cmd.sv
// Directed bench for nios_sdram_com_cmd: bus writes/reads, beat
// ordering, overflow, enable gating, flush and mid-run reset.
module tb_nios_sdram_com_cmd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_port;

  int          n_run = 0;
  int          n_fail = 0;
  logic [15:0] acc [$];
  logic [31:0] rd;

  nios_sdram_com_cmd dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) begin
      acc.push_back(out_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a,
                           input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a,
                          output logic [31:0] d);
    address = a;
    read    = 1'b1;
    step();
    d       = readdata;
    read    = 1'b0;
  endtask

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc.size()) return 32'(acc[i]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    step();
    step(2);
    reset = 1'b0;

    // reset state
    check("rst_readdata", readdata, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_port", 32'(out_port), 32'h0);
    check("rst_odata", 32'(out_data), 32'h0);
    bus_read(2'd0, rd); check("rst_r0", rd, 32'h0);
    bus_read(2'd1, rd); check("rst_r1", rd, 32'h1);
    bus_read(2'd2, rd); check("rst_r2", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_r3", rd, 32'h0);

    // back-to-back stream with enable and ready
    bus_write(2'd2, 32'h1);
    out_ready = 1'b1;
    acc.delete();
    address   = 2'd0;
    write     = 1'b1;
    writedata = 32'h1234;
    step();
    check("bb_v_n1", 32'(out_valid), 32'h0);
    writedata = 32'hABCD;
    step();
    check("bb_v_n2", 32'(out_valid), 32'h1);
    check("bb_d_n2", 32'(out_data), 32'h1234);
    writedata = 32'h0F0F;
    step();
    write = 1'b0;
    check("bb_d_n3", 32'(out_data), 32'hABCD);
    check("bb_p_n3", 32'(out_port), 32'h1234);
    step();
    check("bb_d_n4", 32'(out_data), 32'h0F0F);
    check("bb_p_n4", 32'(out_port), 32'hABCD);
    step();
    check("bb_v_n5", 32'(out_valid), 32'h0);
    check("bb_p_n5", 32'(out_port), 32'h0F0F);
    check("bb_cnt", 32'(acc.size()), 32'd3);
    check("bb_w0", acc_at(0), 32'h1234);
    check("bb_w1", acc_at(1), 32'hABCD);
    check("bb_w2", acc_at(2), 32'h0F0F);

    // overflow with enable off
    bus_write(2'd2, 32'h0);
    acc.delete();
    for (int i = 1; i <= 5; i++) begin
      bus_write(2'd0, 32'(i));
    end
    bus_read(2'd1, rd); check("ovf_stat", rd, 32'h112);
    bus_read(2'd0, rd); check("ovf_rb", rd, 32'h5);
    check("ovf_noemit", 32'(acc.size()), 32'd0);
    bus_write(2'd2, 32'h1);
    step(8);
    check("ovf_cnt", 32'(acc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_w%0d", i), acc_at(i), 32'(i + 1));
    end
    bus_read(2'd1, rd); check("ovf_stat2", rd, 32'h101);
    bus_write(2'd1, 32'h100);
    bus_read(2'd1, rd); check("ovf_clr", rd, 32'h1);

    // stall, then disable with a beat presented
    out_ready = 1'b0;
    acc.delete();
    bus_write(2'd0, 32'h00AA);
    bus_write(2'd0, 32'h00BB);
    bus_write(2'd0, 32'h00CC);
    bus_write(2'd2, 32'h0);
    step(3);
    check("stl_v", 32'(out_valid), 32'h1);
    check("stl_d", 32'(out_data), 32'h00AA);
    bus_read(2'd1, rd); check("stl_stat", rd, 32'h28);
    out_ready = 1'b1;
    step();
    check("stl_v2", 32'(out_valid), 32'h0);
    check("stl_p", 32'(out_port), 32'h00AA);
    step(2);
    check("stl_cnt", 32'(acc.size()), 32'd1);
    check("stl_w0", acc_at(0), 32'h00AA);
    bus_read(2'd1, rd); check("stl_stat2", rd, 32'h08);

    // flush with a beat presented and words queued
    out_ready = 1'b0;
    acc.delete();
    bus_write(2'd0, 32'h00DD);
    bus_write(2'd2, 32'h1);
    step(2);
    bus_write(2'd0, 32'h00EE);
    check("fl_pre_d", 32'(out_data), 32'h00BB);
    bus_read(2'd1, rd); check("fl_pre_st", rd, 32'h2C);
    bus_write(2'd2, 32'h3);
    check("fl_v", 32'(out_valid), 32'h0);
    check("fl_p", 32'(out_port), 32'h00AA);
    bus_read(2'd1, rd); check("fl_stat", rd, 32'h1);
    bus_read(2'd2, rd); check("fl_ctrl", rd, 32'h1);
    check("fl_noemit", 32'(acc.size()), 32'd0);

    // reset while full with a beat pending
    for (int i = 0; i < 5; i++) begin
      bus_write(2'd0, 32'h11 + 32'(i));
    end
    check("rr_d", 32'(out_data), 32'h11);
    bus_read(2'd1, rd); check("rr_stat", rd, 32'h32);
    acc.delete();
    out_ready = 1'b1;
    reset     = 1'b1;
    step();
    check("rr_v", 32'(out_valid), 32'h0);
    check("rr_d0", 32'(out_data), 32'h0);
    check("rr_p", 32'(out_port), 32'h0);
    check("rr_rd", readdata, 32'h0);
    reset = 1'b0;
    step(3);
    check("rr_v2", 32'(out_valid), 32'h0);
    check("rr_hs", 32'(acc.size()), 32'd0);
    bus_read(2'd1, rd); check("rr_stat2", rd, 32'h1);
    bus_read(2'd2, rd); check("rr_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
